mmu_loader: RTL and testbench
=============================

# mmu_loader

Context-switch sequencer for the MMU. On `start` it fetches the full translation table (4*NMMU entries: {ins, sup} × NMMU pages) from memory over a simple request/ack read port. It programs each entry into the MMU through the MMU's single register-write port, using the MMU's two-step protocol: a select write, then an entry write. The CPU is stalled on `busy`; the loader owns the MMU register port while busy.

## Interface
- `RV`, 16, register/data width
- `PA`, RV, physical address width
- `VA`, RV, virtual address width
- `NMMU`, 8, pages per MMU bank; UNTOUCHED = VA-$clog2(NMMU)
- `clk`  in  1  sole clock, all state on rising edge
- `reset_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle request; ignored while `busy`
- `base`  in  RV  byte address of table; bit 0 ignored, captured on accepted `start`
- `busy`  out  1  high while sequencing
- `done`  out  1  one-cycle completion pulse
- `mem_req`  out  1  read request, held until `mem_ack`
- `mem_addr`  out  RV  byte address of requested entry word
- `mem_ack`  in  1  read complete; may assert in the same cycle as `mem_req`
- `mem_rdata`  in  RV  entry word, valid with `mem_ack`
- `mmu_reg_write`  out  1  MMU register write strobe
- `mmu_reg_data`  out  RV  MMU register write data
- `mmu_reg_read`  in  RV  MMU fault register readback

## Operation
- States: IDLE, SAVE, FETCH, SEL, LOAD, RESTORE, DONE.
- IDLE: on `start`, capture `base`, clear index i, and go to SAVE.
- SAVE: latch `mmu_reg_read` into r_saved, then go to FETCH.
- FETCH: drive `mem_req`=1 and `mem_addr`=base+2*i (mod 2^RV). On `mem_ack`, latch `mem_rdata` into r_entry and go to SEL.
- SEL: drive `mmu_reg_write`=1 with select-write data:
  - bits [VA-1:UNTOUCHED] = i[$clog2(NMMU)-1:0] (page)
  - bit 4 = i[$clog2(NMMU)+1] (ins)
  - bit 3 = i[$clog2(NMMU)] (sup)
  - bits 2:0 = 0; all other bits 0
- LOAD: drive `mmu_reg_write`=1 with data {r_entry[RV-1:1], 1'b1}. The entry word format is: upper PA-UNTOUCHED bits = physical page, bit 2 = writeable, bit 1 = valid, bit 0 don't-care.
  - If i = 4*NMMU-1, go to RESTORE. Otherwise increment i and go to FETCH.
- RESTORE: write {r_saved[RV-1:1], 1'b0}, restoring the fault address, ins, sup, write and valid fields. Then go to DONE.
- DONE: `done`=1, `busy`=0; return to IDLE.
- Entry order is i ascending: data entries (ins=0) first, then instruction entries. The writeable bit of ins=1 entries is discarded by the MMU; the loader still sends it.
- `busy`=1 in SAVE, FETCH, SEL, LOAD and RESTORE. `mmu_reg_write`=1 only in SEL, LOAD and RESTORE. `mmu_reg_data` is 0 whenever `mmu_reg_write`=0.
- Reset values: state IDLE; `busy`, `done`, `mem_req`, `mmu_reg_write` = 0; `mem_addr`, `mmu_reg_data`, i, r_entry, r_saved = 0.
- Reset mid-sequence returns to IDLE immediately and leaves the MMU partially loaded; software must re-issue `start`.
- `start` coincident with DONE is ignored. `mem_ack` outside FETCH is ignored.

## Timing
- `start` accepted at edge T: `busy`=1 from T+1 (SAVE).
- Per entry: FETCH for 1+W cycles (W = cycles `mem_ack` lags `mem_req`), then SEL for 1 cycle, then LOAD for 1 cycle.
- With zero-wait ack and NMMU=8: `busy` lasts 1+32*3+1 = 98 cycles, and `done` is high in the cycle after the 98th.
- `mem_addr` is stable for the whole FETCH dwell. `mem_req` drops in the cycle after ack.
- MMU writes take effect at the edge ending the strobe cycle.

## Configuration
- `MMU_LOADER_SAVE_EN` defined: SAVE and RESTORE are present; the fault registers are preserved across a load.
- `MMU_LOADER_SAVE_EN` undefined: IDLE goes directly to FETCH and the last LOAD goes directly to DONE.
  - `busy` lasts 96 cycles (NMMU=8, zero wait).
  - The fault registers are left at ins=1, sup=1, page=NMMU-1, write=0, valid=0.
  - `mmu_reg_read` is unused.

## Test plan
- **Full load, zero wait:** base=16'h1000, NMMU=8, memory word k = {k[4:0],8'h00,3'b011}, `mmu_reg_read`=16'h0016 → 64 writes alternate SEL/LOAD, 32 reads at 16'h1000..16'h103E. RESTORE data = 16'h0016. `done` is high 98 cycles after `start`, and MMU r_vtop[i]=i[4:0] for all i.
- **Wait states:** `mem_ack` 3 cycles after `mem_req` → `busy` lasts 1+32*6+1 = 194 cycles. `mem_addr` holds during each wait and there are no spurious `mmu_reg_write` strobes.
- **Address wrap:** base=16'hFFFC → reads at 16'hFFFC, 16'hFFFE, 16'h0000, …, 16'h003A.
- **Start while busy:** second `start` pulse at cycle 10 → ignored; exactly one `done` pulse and 64 table writes.
- **Reset mid-run:** assert `reset_n`=0 during entry 5 LOAD → outputs go to 0 the same cycle. After release plus `start`, a full 98-cycle sequence completes from i=0.
- **Macro off:** `MMU_LOADER_SAVE_EN` undefined → 96-cycle `busy`, no RESTORE write, and MMU fault readback = {3'b111,8'h00,5'b11000}.

Source files
------------

// File: rtl/mmu_loader.sv
// Context-switch sequencer: fetches the 4*NMMU-entry translation table and programs it into the MMU.
// Define MMU_LOADER_SAVE_EN to preserve the MMU fault registers across a load (SAVE/RESTORE states).
module mmu_loader #(
    parameter int unsigned RV   = 16,
    parameter int unsigned PA   = RV,
    parameter int unsigned VA   = RV,
    parameter int unsigned NMMU = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [RV-1:0] base,
    output logic          busy,
    output logic          done,
    output logic          mem_req,
    output logic [RV-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [RV-1:0] mem_rdata,
    output logic          mmu_reg_write,
    output logic [RV-1:0] mmu_reg_data,
    input  logic [RV-1:0] mmu_reg_read
);

    localparam int unsigned PG_W      = $clog2(NMMU);
    localparam int unsigned UNTOUCHED = VA - PG_W;
    localparam int unsigned IW        = PG_W + 2;
    localparam logic [IW-1:0] LAST    = IW'(4 * NMMU - 1);
    localparam int unsigned pa_unused = PA;

    typedef enum logic [2:0] {
        S_IDLE, S_SAVE, S_FETCH, S_SEL, S_LOAD, S_RESTORE, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic [RV-1:1] base_q, base_d;
    logic [RV-1:1] r_entry_q, r_entry_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          mem_req_q, mem_req_d;
    logic [RV-1:0] mem_addr_q, mem_addr_d;
    logic          mmu_reg_write_q, mmu_reg_write_d;
    logic [RV-1:0] mmu_reg_data_q, mmu_reg_data_d;
    logic [RV-1:0] sel_data;

`ifdef MMU_LOADER_SAVE_EN
    logic [RV-1:1] r_saved_q, r_saved_d;
    logic          unused_bits;
    assign unused_bits = ^{base[0], mem_rdata[0], mmu_reg_read[0]};
`else
    logic          unused_bits;
    assign unused_bits = ^{base[0], mem_rdata[0], mmu_reg_read};
`endif

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        base_d    = base_q;
        r_entry_d = r_entry_q;
`ifdef MMU_LOADER_SAVE_EN
        r_saved_d = r_saved_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d = base[RV-1:1];
                    i_d    = '0;
`ifdef MMU_LOADER_SAVE_EN
                    state_d = S_SAVE;
`else
                    state_d = S_FETCH;
`endif
                end
            end
`ifdef MMU_LOADER_SAVE_EN
            S_SAVE: begin
                r_saved_d = mmu_reg_read[RV-1:1];
                state_d   = S_FETCH;
            end
            S_RESTORE: state_d = S_DONE;
`endif
            S_FETCH: begin
                if (mem_ack) begin
                    r_entry_d = mem_rdata[RV-1:1];
                    state_d   = S_SEL;
                end
            end
            S_SEL: state_d = S_LOAD;
            S_LOAD: begin
                if (i_q == LAST) begin
`ifdef MMU_LOADER_SAVE_EN
                    state_d = S_RESTORE;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    i_d     = i_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered with the state.
    always_comb begin
        sel_data                   = '0;
        sel_data[VA-1:UNTOUCHED]   = i_d[PG_W-1:0];
        sel_data[4]                = i_d[PG_W+1];
        sel_data[3]                = i_d[PG_W];

        busy_d          = (state_d == S_SAVE) || (state_d == S_FETCH) || (state_d == S_SEL) ||
                          (state_d == S_LOAD) || (state_d == S_RESTORE);
        done_d          = (state_d == S_DONE);
        mem_req_d       = (state_d == S_FETCH);
        mmu_reg_write_d = (state_d == S_SEL) || (state_d == S_LOAD) || (state_d == S_RESTORE);
        mem_addr_d      = mem_addr_q;
        if (state_d == S_FETCH) begin
            mem_addr_d = {base_d, 1'b0} + RV'({i_d, 1'b0});
        end

        case (state_d)
            S_SEL:     mmu_reg_data_d = sel_data;
            S_LOAD:    mmu_reg_data_d = {r_entry_d, 1'b1};
`ifdef MMU_LOADER_SAVE_EN
            S_RESTORE: mmu_reg_data_d = {r_saved_d, 1'b0};
`endif
            default:   mmu_reg_data_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            i_q             <= '0;
            base_q          <= '0;
            r_entry_q       <= '0;
`ifdef MMU_LOADER_SAVE_EN
            r_saved_q       <= '0;
`endif
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            mem_req_q       <= 1'b0;
            mem_addr_q      <= '0;
            mmu_reg_write_q <= 1'b0;
            mmu_reg_data_q  <= '0;
        end else begin
            state_q         <= state_d;
            i_q             <= i_d;
            base_q          <= base_d;
            r_entry_q       <= r_entry_d;
`ifdef MMU_LOADER_SAVE_EN
            r_saved_q       <= r_saved_d;
`endif
            busy_q          <= busy_d;
            done_q          <= done_d;
            mem_req_q       <= mem_req_d;
            mem_addr_q      <= mem_addr_d;
            mmu_reg_write_q <= mmu_reg_write_d;
            mmu_reg_data_q  <= mmu_reg_data_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign mem_req       = mem_req_q;
    assign mem_addr      = mem_addr_q;
    assign mmu_reg_write = mmu_reg_write_q;
    assign mmu_reg_data  = mmu_reg_data_q;

endmodule

// File: tb/tb_mmu_loader.sv
// Scoreboard bench for mmu_loader: expected reads and MMU writes are queued at start, popped as the DUT emits them.
module tb_mmu_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base = '0;
    logic        busy, done, mem_req, mmu_reg_write;
    logic [15:0] mem_addr, mmu_reg_data;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] mmu_reg_read = '0;

`ifdef MMU_LOADER_SAVE_EN
    localparam bit SAVE_EN = 1'b1;
`else
    localparam bit SAVE_EN = 1'b0;
`endif

    mmu_loader #(.RV(16), .PA(16), .VA(16), .NMMU(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base(base),
        .busy(busy), .done(done), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mmu_reg_write(mmu_reg_write), .mmu_reg_data(mmu_reg_data),
        .mmu_reg_read(mmu_reg_read)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    logic [15:0] wq[$];
    logic [15:0] aq[$];
    int wait_cyc = 0;
    int data_mode = 0;
    int exp_busy = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int load_cnt = 0;
    int wcnt = 0;
    bit stray_ack = 1'b0;
    bit mon_en = 1'b0;
    logic [15:0] base_eff = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] data_of(input int unsigned k, input int mode);
        logic [31:0] kk;
        kk = k;
        if (mode == 0) return {kk[4:0], 8'h00, 3'b011};
        return 16'((kk * 32'd40503) ^ 32'h5A3C);
    endfunction

    always @(negedge clk) begin : mon
        logic [15:0] off;
        if (mon_en) begin
            if (busy) busy_cnt++;
            if (mmu_reg_write) begin
                chk("wr_pending", 32'(wq.size() != 0), 1);
                if (wq.size() != 0) chk("mmu_wdata", 32'(mmu_reg_data), 32'(wq.pop_front()));
                chk("wr_busy", 32'(busy), 1);
                if (mmu_reg_data[0]) load_cnt++;
            end else begin
                chk("data_idle", 32'(mmu_reg_data), 0);
            end
            if (done) begin
                done_cnt++;
                chk("busy_len", busy_cnt, exp_busy);
                chk("done_busy", 32'(busy), 0);
                chk("wq_left", 32'(wq.size()), 0);
                chk("aq_left", 32'(aq.size()), 0);
            end
            if (mem_req) begin
                chk("rd_pending", 32'(aq.size() != 0), 1);
                if (aq.size() != 0) chk("mem_addr", 32'(mem_addr), 32'(aq[0]));
                if (wcnt >= wait_cyc) begin
                    off       = mem_addr - base_eff;
                    mem_ack   = 1'b1;
                    mem_rdata = data_of(32'(off >> 1), data_mode);
                    if (aq.size() != 0) void'(aq.pop_front());
                    wcnt = 0;
                end else begin
                    wcnt++;
                    mem_ack = 1'b0;
                end
            end else begin
                wcnt      = 0;
                mem_ack   = stray_ack;
                mem_rdata = stray_ack ? 16'hDEAD : 16'h0000;
            end
        end
    end

    task automatic prep(input logic [15:0] b, input int w, input logic [15:0] rr,
                        input int mode, input bit stray);
        logic [15:0] sel, ent;
        base_eff = b & 16'hFFFE;
        wait_cyc = w;
        mmu_reg_read = rr;
        data_mode = mode;
        stray_ack = stray;
        wq.delete();
        aq.delete();
        for (int i = 0; i < 32; i++) begin
            aq.push_back(base_eff + 16'(2 * i));
            sel = (16'(i % 8) << 13) | (16'((i / 16) % 2) << 4) | (16'((i / 8) % 2) << 3);
            ent = data_of(i, mode);
            wq.push_back(sel);
            wq.push_back({ent[15:1], 1'b1});
        end
        if (SAVE_EN) wq.push_back({rr[15:1], 1'b0});
        exp_busy = SAVE_EN ? 2 + 32 * (3 + w) : 32 * (3 + w);
        busy_cnt = 0;
        load_cnt = 0;
        @(negedge clk); #1;
        base  = b;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        base  = 16'hBEEF;
    endtask

    task automatic wait_done(input int extra_at);
        int d0;
        d0 = done_cnt;
        for (int c = 0; c < 3000 && done_cnt == d0; c++) begin
            @(negedge clk); #1;
            start = (c == extra_at);
        end
        start = 1'b0;
        chk("done_seen", done_cnt - d0, 1);
        repeat (4) @(negedge clk);
        #1;
        chk("done_once", done_cnt - d0, 1);
        chk("idle_busy", 32'(busy), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_req"}, 32'(mem_req), 0);
        chk({tag, "_addr"}, 32'(mem_addr), 0);
        chk({tag, "_wr"}, 32'(mmu_reg_write), 0);
        chk({tag, "_wdata"}, 32'(mmu_reg_data), 0);
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        reset_n = 1'b1;
        mon_en  = 1'b1;

        prep(16'h1000, 0, 16'h0016, 0, 1'b0);
        wait_done(-1);

        prep(16'h1001, 3, 16'hA5A7, 1, 1'b1);
        wait_done(-1);

        prep(16'hFFFC, 0, 16'h0016, 1, 1'b0);
        wait_done(-1);

        prep(16'h2000, 0, 16'h1234, 0, 1'b0);
        wait_done(10);

        prep(16'h3000, 1, 16'h7FFF, 1, 1'b0);
        for (int c = 0; c < 1000 && load_cnt < 6; c++) begin
            @(negedge clk); #1;
        end
        chk("reach_load5", load_cnt, 6);
        mon_en  = 1'b0;
        mem_ack = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge clk); #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;
        prep(16'h0400, 0, 16'h0016, 0, 1'b0);
        wait_done(-1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
